// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: ALU operation encoding seen by the issue stage and the ALU.
package rv32i_types_pkg;

  typedef enum logic [3:0] {
    ALU_NONE      = 4'd0,
    ALU_ADD       = 4'd1,
    ALU_SUB       = 4'd2,
    ALU_SLL       = 4'd3,
    ALU_SLT       = 4'd4,
    ALU_SLTU      = 4'd5,
    ALU_XOR       = 4'd6,
    ALU_SRL       = 4'd7,
    ALU_SRA       = 4'd8,
    ALU_OR        = 4'd9,
    ALU_AND       = 4'd10,
    ALU_OPERAND_B = 4'd11
  } ALU_op_enum;

endpackage

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction into ALU op + operands and holds
// the result in a single-entry ID/EX register with valid/ready, stall and flush.
module alu_issue_stage
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output ALU_op_enum            out_alu_op,
  output logic [DATA_WIDTH-1:0] out_alu_a,
  output logic [DATA_WIDTH-1:0] out_alu_b,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_illegal
);

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REG_IDX_W-1:0] rd_idx;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;

  ALU_op_enum            dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_we;
  logic                  dec_illegal;

  logic                  valid_q, valid_d;
  logic                  load_en;
  ALU_op_enum            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [REG_IDX_W-1:0]  rd_q;
  logic                  rd_we_q;
  logic                  illegal_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd_idx = in_instr[11:7];

  assign imm_i = DATA_WIDTH'($signed(in_instr[31:20]));
  assign imm_s = DATA_WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_u = DATA_WIDTH'({in_instr[31:12], 12'b0});
  assign shamt = DATA_WIDTH'(in_instr[24:20]);

  // Instruction decode into ALU op, operands and writeback enable.
  always_comb begin
    dec_op      = ALU_NONE;
    dec_a       = '0;
    dec_b       = '0;
    dec_we      = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        dec_we = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: dec_op = ALU_ADD;
            3'b001: dec_op = ALU_SLL;
            3'b010: dec_op = ALU_SLT;
            3'b011: dec_op = ALU_SLTU;
            3'b100: dec_op = ALU_XOR;
            3'b101: dec_op = ALU_SRL;
            3'b110: dec_op = ALU_OR;
            3'b111: dec_op = ALU_AND;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_a  = in_rs1_data;
        dec_b  = imm_i;
        dec_we = 1'b1;
        case (funct3)
          3'b000: dec_op = ALU_ADD;
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          3'b001: begin
            dec_b = shamt;
            if (funct7 == F7_BASE) dec_op = ALU_SLL;
            else                   dec_illegal = 1'b1;
          end
          3'b101: begin
            dec_b = shamt;
            if (funct7 == F7_BASE)     dec_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_op = ALU_SRA;
            else                       dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_op = ALU_OPERAND_B;
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op = ALU_ADD;
        dec_a  = in_pc;
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OPC_JAL: begin
        dec_op = ALU_ADD;
        dec_a  = in_pc;
        dec_b  = DATA_WIDTH'(4);
        dec_we = 1'b1;
      end
      OPC_JALR: begin
        dec_op      = ALU_ADD;
        dec_a       = in_pc;
        dec_b       = DATA_WIDTH'(4);
        dec_we      = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        dec_op = ALU_ADD;
        dec_a  = in_rs1_data;
        dec_b  = imm_i;
        dec_we = 1'b1;
      end
      OPC_STORE: begin
        dec_op = ALU_ADD;
        dec_a  = in_rs1_data;
        dec_b  = imm_s;
      end
      OPC_BRANCH: begin
        dec_a = in_rs1_data;
        dec_b = in_rs2_data;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings flow as a harmless bubble-like entry.
    if (dec_illegal) begin
      dec_op = ALU_NONE;
      dec_a  = '0;
      dec_b  = '0;
      dec_we = 1'b0;
    end
    if (rd_idx == '0) dec_we = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;

  // Occupancy next-state: flush beats accept, accept beats drain.
  always_comb begin
    load_en = in_valid && in_ready && !flush;
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load_en)   valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= ALU_NONE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        op_q      <= dec_op;
        a_q       <= dec_a;
        b_q       <= dec_b;
        rd_q      <= rd_idx;
        rd_we_q   <= dec_we;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = op_q;
  assign out_alu_a   = a_q;
  assign out_alu_b   = b_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed spec cases plus randomized traffic
// checked against a behavioural decode/occupancy model.
module tb_alu_issue_stage;
  import rv32i_types_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  ALU_op_enum  out_alu_op;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  int   total = 0;
  int   bad = 0;
  logic m_valid = 1'b0;
  ent_t m_e = '0;
  logic exp_ready;
  logic got_ready;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_op(out_alu_op), .out_alu_a(out_alu_a),
    .out_alu_b(out_alu_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_illegal(out_illegal)
  );

  function automatic ent_t obs();
    obs = '{op: out_alu_op, a: out_alu_a, b: out_alu_b, rd: out_rd,
            we: out_rd_we, ill: out_illegal};
  endfunction

  function automatic ent_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we, input logic ill);
    mk = '{op: op, a: a, b: b, rd: rd, we: we, ill: ill};
  endfunction

  // Reference decode, expressed from the ISA rules with plain arithmetic.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    ent_t        e;
    logic [3:0]  tab [8];
    logic        legal;
    logic [6:0]  opc;
    int unsigned f3;
    int unsigned f7;
    logic [31:0] ii;
    logic [31:0] si;
    logic [31:0] ui;
    logic [31:0] sh;
    tab   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc   = ins[6:0];
    f3    = (ins >> 12) & 7;
    f7    = ins >> 25;
    ii    = 32'($signed(ins) >>> 20);
    si    = (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'd31);
    ui    = ins & 32'hFFFF_F000;
    sh    = (ins >> 20) & 32'd31;
    e     = '0;
    e.rd  = ins[11:7];
    legal = 1'b1;
    case (opc)
      7'h33: begin
        e.a = r1; e.b = r2; e.we = 1'b1;
        if (f7 == 0)                e.op = tab[f3];
        else if (f7 == 32 && f3 == 0) e.op = ALU_SUB;
        else if (f7 == 32 && f3 == 5) e.op = ALU_SRA;
        else                          legal = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.we = 1'b1;
        if (f3 == 1) begin
          e.b = sh; e.op = ALU_SLL; legal = (f7 == 0);
        end else if (f3 == 5) begin
          e.b = sh;
          if (f7 == 0)       e.op = ALU_SRL;
          else if (f7 == 32) e.op = ALU_SRA;
          else               legal = 1'b0;
        end else begin
          e.b = ii; e.op = tab[f3];
        end
      end
      7'h37: begin e.op = ALU_OPERAND_B; e.b = ui; e.we = 1'b1; end
      7'h17: begin e.op = ALU_ADD; e.a = pc; e.b = ui; e.we = 1'b1; end
      7'h6F: begin e.op = ALU_ADD; e.a = pc; e.b = 32'd4; e.we = 1'b1; end
      7'h67: begin e.op = ALU_ADD; e.a = pc; e.b = 32'd4; e.we = 1'b1; legal = (f3 == 0); end
      7'h03: begin e.op = ALU_ADD; e.a = r1; e.b = ii; e.we = 1'b1; end
      7'h23: begin e.op = ALU_ADD; e.a = r1; e.b = si; end
      7'h63: begin e.op = ALU_NONE; e.a = r1; e.b = r2; end
      default: legal = 1'b0;
    endcase
    if (!legal) e = mk(ALU_NONE, 32'd0, 32'd0, ins[11:7], 1'b0, 1'b1);
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] w;
    int unsigned k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive at negedge, sample in_ready, then advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fl, input logic ordy, input logic rst_v);
    @(negedge clk);
    rst_n = rst_v; in_valid = v; in_instr = ins; in_pc = pc;
    in_rs1_data = r1; in_rs2_data = r2; flush = fl; out_ready = ordy;
    #1;
    got_ready = in_ready;
    exp_ready = !m_valid || ordy;
    @(posedge clk);
    if (!rst_v) begin
      m_valid = 1'b0; m_e = '0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_ready) begin
      m_valid = 1'b1; m_e = ref_decode(ins, pc, r1, r2);
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'h002081B3, 32'h100, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 32'h100, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || obs() !== ent_t'('0)) begin
      bad++;
      $display("FAIL reset_state: got valid=%0b ent=%h want valid=0 ent=0", out_valid, obs());
    end
    total++;
    if (got_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b want 1", got_ready);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_directed();
    logic [31:0] ins [6];
    logic [31:0] r1 [6];
    ent_t        want [6];
    ins  = '{32'h002081B3, 32'h40435293, 32'h02435293, 32'hABCDE0B7, 32'h00100013, 32'h002081B1};
    r1   = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd0, 32'd5};
    want = '{mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0),
             mk(ALU_SRA, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 1'b0),
             mk(ALU_NONE, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1),
             mk(ALU_OPERAND_B, 32'd0, 32'hABCD_E000, 5'd1, 1'b1, 1'b0),
             mk(ALU_ADD, 32'd0, 32'd1, 5'd0, 1'b0, 1'b0),
             mk(ALU_NONE, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1)};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ins[i], 32'h0000_0400, r1[i], 32'd7, 1'b0, 1'b1, 1'b1);
      total++;
      if (out_valid !== 1'b1 || obs() !== want[i]) begin
        bad++;
        $display("FAIL directed_%0d: got valid=%0b ent=%h want valid=1 ent=%h",
                 i, out_valid, obs(), want[i]);
      end
    end
  endtask

  task automatic test_hold();
    ent_t        held;
    logic [31:0] nxt;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h40208133, 32'h200, 32'd50, 32'd8, 1'b0, 1'b0, 1'b1);
    held = mk(ALU_SUB, 32'd50, 32'd8, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      total++;
      if (got_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready_%0d: got %0b want 0", i, got_ready);
      end
      total++;
      if (out_valid !== 1'b1 || obs() !== held) begin
        bad++;
        $display("FAIL hold_data_%0d: got valid=%0b ent=%h want valid=1 ent=%h",
                 i, out_valid, obs(), held);
      end
    end
    nxt = 32'h00C10513;
    step(1'b1, nxt, 32'h300, 32'd100, 32'd0, 1'b0, 1'b1, 1'b1);
    total++;
    if (got_ready !== 1'b1 || out_valid !== 1'b1 ||
        obs() !== mk(ALU_ADD, 32'd100, 32'd12, 5'd10, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL hold_release: got ready=%0b valid=%0b ent=%h", got_ready, out_valid, obs());
    end
  endtask

  task automatic test_flush();
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
    total++;
    if (got_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_accept: got ready=%0b valid=%0b want ready=1 valid=0", got_ready, out_valid);
    end
    step(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 32'h0, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_held: got valid=%0b want 0", out_valid);
    end
    step(1'b1, 32'h0062F233, 32'h0, 32'hF0F0, 32'h0FF0, 1'b0, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b1 || obs() !== mk(ALU_AND, 32'hF0F0, 32'h0FF0, 5'd4, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL flush_recover: got valid=%0b ent=%h", out_valid, obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins, pc, r1, r2;
    int          nvalid;
    nvalid = 0;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ins = rand_instr(); pc = $urandom; r1 = $urandom; r2 = $urandom;
      step(1'b1, ins, pc, r1, r2, 1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) nvalid++;
      total++;
      if (out_valid !== 1'b1 || obs() !== ref_decode(ins, pc, r1, r2)) begin
        bad++;
        $display("FAIL b2b_%0d: instr=%h got valid=%0b ent=%h want ent=%h",
                 i, ins, out_valid, obs(), ref_decode(ins, pc, r1, r2));
      end
    end
    total++;
    if (nvalid != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 8", nvalid);
    end
  endtask

  task automatic test_random();
    logic v, fl, ordy;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, rand_instr(), $urandom, $urandom, $urandom, fl, ordy, 1'b1);
      total++;
      if (got_ready !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready_%0d: got %0b want %0b", i, got_ready, exp_ready);
      end
      total++;
      if (out_valid !== m_valid || (m_valid && obs() !== m_e)) begin
        bad++;
        $display("FAIL rand_out_%0d: got valid=%0b ent=%h want valid=%0b ent=%h",
                 i, out_valid, obs(), m_valid, m_e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hABCDE0B7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || obs() !== ent_t'('0)) begin
      bad++;
      $display("FAIL reset_midflight: got valid=%0b ent=%h want valid=0 ent=0", out_valid, obs());
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
